// File: rtl/multi_operand_accumulating_adder.sv
// rtl/multi_operand_accumulating_adder.sv - serial valid/ready accumulator summing up to OPERANDS unsigned operands per group
module multi_operand_accumulating_adder #(
    parameter int WIDTH       = 2,
    parameter int OPERANDS    = 8,
    localparam int SUM_WIDTH  = WIDTH + $clog2(OPERANDS),
    localparam int CNT_WIDTH  = $clog2(OPERANDS + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CLEAR,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     IN_DATA,
    input  logic                 IN_LAST,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [SUM_WIDTH-1:0] SUM,
    output logic [CNT_WIDTH-1:0] COUNT
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [SUM_WIDTH-1:0] acc;
    logic [SUM_WIDTH-1:0] acc_next;
    logic [SUM_WIDTH-1:0] sum_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CNT_WIDTH-1:0] count_next;
    logic [SUM_WIDTH-1:0] acc_sum;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 accept;
    logic                 group_end;

    // Next-state, datapath update and handshake outputs; CLEAR overrides everything but RST
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        sum_next   = SUM;
        count_next = COUNT;
        IN_READY   = (state == ACCUM);
        OUT_VALID  = (state == HOLD);
        acc_sum    = acc + SUM_WIDTH'(IN_DATA);
        cnt_inc    = cnt + CNT_WIDTH'(1);
        accept     = IN_VALID && (state == ACCUM);
        // The OPERANDS-th operand closes the group even without IN_LAST
        group_end  = IN_LAST || (cnt == CNT_WIDTH'(OPERANDS - 1));

        if (CLEAR) begin
            state_next = ACCUM;
            acc_next   = '0;
            cnt_next   = '0;
            sum_next   = '0;
            count_next = '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (group_end) begin
                            sum_next   = acc_sum;
                            count_next = cnt_inc;
                            acc_next   = '0;
                            cnt_next   = '0;
                            state_next = HOLD;
                        end else begin
                            acc_next = acc_sum;
                            cnt_next = cnt_inc;
                        end
                    end
                end
                HOLD: begin
                    // Result is held stable until consumed; no input is taken meanwhile
                    if (OUT_READY) begin
                        state_next = ACCUM;
                    end
                end
                default: state_next = ACCUM;
            endcase
        end
    end

    // State, accumulator and result registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            SUM   <= '0;
            COUNT <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            SUM   <= sum_next;
            COUNT <= count_next;
        end
    end

endmodule

// File: tb/tb_multi_operand_accumulating_adder.sv
// tb/tb_multi_operand_accumulating_adder.sv - directed self-checking bench for multi_operand_accumulating_adder
module tb_multi_operand_accumulating_adder;

    logic       clk;
    logic       rst;

    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] sum;
    logic [3:0] count;

    logic       b_clear;
    logic       b_in_valid;
    logic       b_in_ready;
    logic [3:0] b_in_data;
    logic       b_in_last;
    logic       b_out_valid;
    logic       b_out_ready;
    logic [6:0] b_sum;
    logic [2:0] b_count;

    int checks = 0;
    int errors = 0;

    multi_operand_accumulating_adder #(.WIDTH(2), .OPERANDS(8)) dut_a (
        .CLK       (clk),
        .RST       (rst),
        .CLEAR     (clear),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_DATA   (in_data),
        .IN_LAST   (in_last),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .SUM       (sum),
        .COUNT     (count)
    );

    multi_operand_accumulating_adder #(.WIDTH(4), .OPERANDS(5)) dut_b (
        .CLK       (clk),
        .RST       (rst),
        .CLEAR     (b_clear),
        .IN_VALID  (b_in_valid),
        .IN_READY  (b_in_ready),
        .IN_DATA   (b_in_data),
        .IN_LAST   (b_in_last),
        .OUT_VALID (b_out_valid),
        .OUT_READY (b_out_ready),
        .SUM       (b_sum),
        .COUNT     (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_a(input logic [1:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("a_accept_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take_a();
        @(negedge clk);
        check("a_valid_before_take", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("a_valid_after_take", out_valid, 0);
        check("a_ready_after_take", in_ready, 1);
    endtask

    task automatic send_b(input logic [3:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_last  = l;
        while (!b_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b_accept_wait", b_in_ready, 1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    task automatic take_b();
        @(negedge clk);
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        check("b_valid_after_take", b_out_valid, 0);
    endtask

    initial begin
        int len;
        int exp_sum;
        logic [3:0] d;
        logic l;

        rst = 1'b1;
        clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_count", count, 0);
        rst = 1'b0;

        // Eight back-to-back operands of 3: forced group end at OPERANDS
        for (int i = 0; i < 7; i++) send_a(2'd3, 1'b0);
        check("t1_no_early_valid", out_valid, 0);
        send_a(2'd3, 1'b0);
        check("t1_valid_latency", out_valid, 1);
        check("t1_sum", sum, 24);
        check("t1_count", count, 8);
        check("t1_in_ready_held", in_ready, 0);
        take_a();
        check("t1_sum_kept", sum, 24);
        check("t1_count_kept", count, 8);

        // Early termination with IN_LAST
        send_a(2'd1, 1'b0);
        send_a(2'd2, 1'b0);
        send_a(2'd0, 1'b1);
        check("t2_sum", sum, 3);
        check("t2_count", count, 3);
        take_a();
        send_a(2'd2, 1'b1);
        check("t2_single_sum", sum, 2);
        check("t2_single_count", count, 1);
        take_a();

        // Stall in HOLD with valid input present
        send_a(2'd3, 1'b0);
        send_a(2'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 2'd3;
            check("t3_stall_sum", sum, 6);
            check("t3_stall_count", count, 2);
            check("t3_stall_valid", out_valid, 1);
            check("t3_stall_ready", in_ready, 0);
        end
        @(negedge clk);
        check("t3_stall_sum_end", sum, 6);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("t3_released", out_valid, 0);
        send_a(2'd1, 1'b0);
        send_a(2'd1, 1'b1);
        check("t3_no_leak_sum", sum, 2);
        check("t3_no_leak_count", count, 2);
        take_a();

        // CLEAR mid-group drops the coincident operand
        send_a(2'd3, 1'b0);
        send_a(2'd3, 1'b0);
        send_a(2'd3, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 2'd3;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("t4_clear_valid", out_valid, 0);
        check("t4_clear_ready", in_ready, 1);
        check("t4_clear_sum", sum, 0);
        check("t4_clear_count", count, 0);
        repeat (3) begin
            @(negedge clk);
            check("t4_no_valid", out_valid, 0);
        end
        send_a(2'd1, 1'b1);
        check("t4_after_sum", sum, 1);
        check("t4_after_count", count, 1);
        take_a();

        // Asynchronous reset mid-group
        send_a(2'd3, 1'b0);
        send_a(2'd3, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_grp_valid", out_valid, 0);
        check("t5_grp_ready", in_ready, 1);
        check("t5_grp_sum", sum, 0);
        check("t5_grp_count", count, 0);
        #1;
        rst = 1'b0;
        send_a(2'd1, 1'b1);
        check("t5_lost_sum", sum, 1);
        check("t5_lost_count", count, 1);
        // Asynchronous reset while holding a result
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_hold_valid", out_valid, 0);
        check("t5_hold_ready", in_ready, 1);
        check("t5_hold_sum", sum, 0);
        check("t5_hold_count", count, 0);
        #1;
        rst = 1'b0;

        // Wider instance: full group of maximum operands
        for (int i = 0; i < 5; i++) send_b(4'd15, 1'b0);
        check("b_full_valid", b_out_valid, 1);
        check("b_full_sum", b_sum, 75);
        check("b_full_count", b_count, 5);
        take_b();

        // Random groups with random gaps against a running reference sum
        for (int g = 0; g < 1000; g++) begin
            len = int'($urandom_range(1, 5));
            exp_sum = 0;
            for (int k = 0; k < len; k++) begin
                d = 4'($urandom_range(0, 15));
                l = (k == len - 1) ? ((len < 5) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_b(d, l);
                exp_sum += int'(d);
            end
            check("b_rand_valid", b_out_valid, 1);
            check("b_rand_sum", b_sum, exp_sum);
            check("b_rand_count", b_count, len);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            take_b();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
